sample_fetch: RTL and testbench

- Downstream consumer of the cellular-RAM controller in the synthesizer.
- Streams a contiguous block of 16-bit audio samples out of external RAM, from start_addr through end_addr inclusive.
- Issues single-word read requests over a req/ack handshake and buffers the returned words in a small FIFO.
- Releases one sample per sample-rate tick to the audio output stage (PWM/DAC).

---
 rtl/sample_pkg.sv | 25 ++
 rtl/sample_fifo.sv | 68 ++++++
 rtl/sample_fetch.sv | 225 ++++++++++++++++++++++
 tb/tb_sample_fetch.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared types and constants for the sample fetch block.
// Holds the fetch FSM encoding and default bus widths / divider ratio.
package sample_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int CLK_DIV_44K1 = 1134;
  localparam int ADDR_W_DEF   = 26;
  localparam int DATA_W_DEF   = 16;

  // Width of a counter that must reach div-1; never narrower than one bit.
  function automatic int div_width(input int div);
    if (div > 1) begin
      return $clog2(div);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data and a
// synchronous flush that takes priority over push and pop.
module sample_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty    = (count_r == CNT_W'(0));
  assign full     = (count_r == CNT_W'(DEPTH));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Qualify requests against the current fill level.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
  end

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sample_fetch.sv
// Streams start_addr..end_addr from external RAM through a FIFO, one sample per
// divider tick. Define SAMPLE_FETCH_LOOP_EN to loop the block until play falls.
module sample_fetch
  import sample_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = CLK_DIV_44K1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_strobe,
  output logic              busy,
  output logic              underrun
);

  localparam int DIV_W = div_width(CLK_DIV);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_r;
  fetch_state_e      next_state_s;
  logic              play_d_r;
  logic [ADDR_W-1:0] end_r;
`ifdef SAMPLE_FETCH_LOOP_EN
  logic [ADDR_W-1:0] start_r;
`endif
  logic              rd_req_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] sample_out_r;
  logic              strobe_r;
  logic              busy_r;
  logic              underrun_r;
  logic              abort_r;
  logic [DIV_W-1:0]  div_r;

  logic              play_rise_s;
  logic              start_ok_s;
  logic              tick_s;
  logic              abort_s;
  logic              last_addr_s;
  logic              live_s;
  logic              push_s;
  logic              pop_s;
  logic              flush_s;
  logic              underrun_set_s;
  logic [DATA_W-1:0] fifo_dout_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;

  assign rd_req        = rd_req_r;
  assign rd_addr       = rd_addr_r;
  assign sample_out    = sample_out_r;
  assign sample_strobe = strobe_r;
  assign busy          = busy_r;
  assign underrun      = underrun_r;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (rd_data),
    .pop       (pop_s),
    .pop_data  (fifo_dout_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // Start qualification, tick decode and abort detection.
  always_comb begin
    play_rise_s = play && !play_d_r;
    start_ok_s  = play_rise_s && (end_addr >= start_addr);
    tick_s      = busy_r && (div_r == DIV_W'(CLK_DIV - 1));
    abort_s     = abort_r || !play;
    last_addr_s = (rd_addr_r == end_r);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; an abort in WAIT still waits for the pending ack.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (!play) begin
          next_state_s = IDLE;
        end else if (fifo_count_s < CNT_W'(FIFO_DEPTH)) begin
          next_state_s = WAIT;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT: begin
        if (!rd_ack) begin
          next_state_s = WAIT;
        end else if (abort_s) begin
          next_state_s = IDLE;
        end else if (last_addr_s) begin
`ifdef SAMPLE_FETCH_LOOP_EN
          next_state_s = REQ;
`else
          next_state_s = DRAIN;
`endif
        end else begin
          next_state_s = REQ;
        end
      end
      DRAIN: begin
        if (!play) begin
          next_state_s = IDLE;
        end else if (tick_s && fifo_empty_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FIFO and status controls; nothing is pushed or popped once aborting.
  always_comb begin
    live_s         = (state_r != IDLE) && !abort_s;
    push_s         = (state_r == WAIT) && rd_ack && !abort_s && !fifo_full_s;
    pop_s          = tick_s && live_s && !fifo_empty_s;
    underrun_set_s = tick_s && live_s && fifo_empty_s &&
                     ((state_r == REQ) || (state_r == WAIT));
    if (state_r == IDLE) begin
      flush_s = start_ok_s;
    end else begin
      flush_s = (next_state_s == IDLE);
    end
  end

  // Registered outputs, address sequencing, divider and abort tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      play_d_r     <= 1'b0;
      end_r        <= '0;
`ifdef SAMPLE_FETCH_LOOP_EN
      start_r      <= '0;
`endif
      rd_req_r     <= 1'b0;
      rd_addr_r    <= '0;
      sample_out_r <= '0;
      strobe_r     <= 1'b0;
      busy_r       <= 1'b0;
      underrun_r   <= 1'b0;
      abort_r      <= 1'b0;
      div_r        <= '0;
    end else begin
      play_d_r <= play;
      rd_req_r <= (next_state_s == WAIT);
      busy_r   <= (next_state_s != IDLE);
      strobe_r <= pop_s;
      if (pop_s) begin
        sample_out_r <= fifo_dout_s;
      end
      // The divider restarts from zero whenever playback (re)starts.
      if (busy_r && (next_state_s != IDLE)) begin
        div_r <= tick_s ? '0 : (div_r + DIV_W'(1));
      end else begin
        div_r <= '0;
      end
      if ((state_r == IDLE) && start_ok_s) begin
        end_r      <= end_addr;
`ifdef SAMPLE_FETCH_LOOP_EN
        start_r    <= start_addr;
`endif
        rd_addr_r  <= start_addr;
        underrun_r <= 1'b0;
        abort_r    <= 1'b0;
      end else begin
        if (underrun_set_s) begin
          underrun_r <= 1'b1;
        end
        if (push_s) begin
          if (last_addr_s) begin
`ifdef SAMPLE_FETCH_LOOP_EN
            rd_addr_r <= start_r;
`else
            rd_addr_r <= rd_addr_r;
`endif
          end else begin
            rd_addr_r <= rd_addr_r + ADDR_W'(1);
          end
        end
        if (next_state_s == IDLE) begin
          abort_r <= 1'b0;
        end else if ((state_r == WAIT) && !play) begin
          abort_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_fetch.sv
// Directed bench for sample_fetch: a RAM responder with programmable ack
// latency, a strobe logger and one task per scenario.
module tb_sample_fetch;

  localparam int AW = 26;
  localparam int DW = 16;
  localparam int D  = 40;

  logic          clk;
  logic          rst;
  logic          play;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] sample_out;
  logic          sample_strobe;
  logic          busy;
  logic          underrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_lat  = 3;
  int unstable = 0;
  int start_cyc;

  logic [AW-1:0] req_q[$];
  logic [DW-1:0] strobe_q[$];
  int            strobe_cyc_q[$];

  logic [AW-1:0] resp_addr;
  logic [AW:0]   resp_dbl;

  sample_fetch #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (8),
    .CLK_DIV    (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .play          (play),
    .start_addr    (start_addr),
    .end_addr      (end_addr),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .sample_out    (sample_out),
    .sample_strobe (sample_strobe),
    .busy          (busy),
    .underrun      (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // RAM model: logs each request, acks ack_lat cycles later with data = 2*addr.
  initial begin
    rd_ack  = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_req && rst) begin
        resp_addr = rd_addr;
        req_q.push_back(resp_addr);
        for (int k = 0; k < ack_lat; k++) begin
          @(posedge clk); #1;
          if (rd_req && (rd_addr !== resp_addr)) unstable = unstable + 1;
        end
        resp_dbl = {resp_addr, 1'b0};
        rd_ack   = 1'b1;
        rd_data  = resp_dbl[DW-1:0];
        @(posedge clk); #1;
        rd_ack = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (sample_strobe) begin
      strobe_q.push_back(sample_out);
      strobe_cyc_q.push_back(cyc);
    end
  end

  task automatic start_play(input logic [AW-1:0] s, input logic [AW-1:0] e);
    req_q.delete();
    strobe_q.delete();
    strobe_cyc_q.delete();
    unstable   = 0;
    start_addr = s;
    end_addr   = e;
    @(posedge clk); #1;
    play      = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic wait_busy_low(input int limit, output int fall, output bit timed_out);
    timed_out = 1'b1;
    fall      = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin
        timed_out = 1'b0;
        fall      = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; play = 1'b0; start_addr = '0; end_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
    checks++; if (rd_addr !== 26'd0) begin failures++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    checks++; if (sample_out !== 16'd0 || sample_strobe !== 1'b0) begin failures++; $display("FAIL reset_sample: got %h/%b want 0/0", sample_out, sample_strobe); end
    checks++; if (busy !== 1'b0 || underrun !== 1'b0) begin failures++; $display("FAIL reset_status: got busy=%b underrun=%b want 0/0", busy, underrun); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [AW-1:0] exp_a [4] = '{26'h10, 26'h11, 26'h12, 26'h13};
    logic [DW-1:0] exp_d [4] = '{16'h0020, 16'h0022, 16'h0024, 16'h0026};
    int fall; bit to;
    ack_lat = 3;
    start_play(26'h10, 26'h13);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    wait_busy_low(10 * D, fall, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout: busy still %b want 0", busy); end
    checks++; if (fall !== start_cyc + 1 + 5 * D) begin failures++; $display("FAIL basic_fall_cycle: got %0d want %0d", fall, start_cyc + 1 + 5 * D); end
    checks++; if (req_q.size() !== 4) begin failures++; $display("FAIL basic_req_count: got %0d want 4", req_q.size()); end
    checks++; if (strobe_q.size() !== 4) begin failures++; $display("FAIL basic_strobe_count: got %0d want 4", strobe_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (i >= req_q.size() || req_q[i] !== exp_a[i]) begin failures++; $display("FAIL basic_req_addr[%0d]: got %h want %h", i, (i < req_q.size()) ? req_q[i] : '1, exp_a[i]); end
      checks++; if (i >= strobe_q.size() || strobe_q[i] !== exp_d[i]) begin failures++; $display("FAIL basic_sample[%0d]: got %h want %h", i, (i < strobe_q.size()) ? strobe_q[i] : '1, exp_d[i]); end
      checks++; if (i >= strobe_cyc_q.size() || strobe_cyc_q[i] !== start_cyc + 1 + (i + 1) * D) begin failures++; $display("FAIL basic_tick_cycle[%0d]: got %0d want %0d", i, (i < strobe_cyc_q.size()) ? strobe_cyc_q[i] : -1, start_cyc + 1 + (i + 1) * D); end
    end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL basic_underrun: got %b want 0", underrun); end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL basic_addr_stable: got %0d changes want 0", unstable); end
    play = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure;
    int fall; bit to;
    ack_lat = 1;
    start_play(26'h100, 26'h114);
    repeat (D - 3) @(negedge clk);
    checks++; if (req_q.size() !== 8) begin failures++; $display("FAIL bp_stall_count: got %0d want 8", req_q.size()); end
    checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL bp_stall_req: got %b want 0", rd_req); end
    repeat (D) @(negedge clk);
    checks++; if (req_q.size() !== 9) begin failures++; $display("FAIL bp_after_tick1: got %0d want 9", req_q.size()); end
    wait_busy_low(30 * D, fall, to);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout: busy still %b want 0", busy); end
    checks++; if (fall !== start_cyc + 1 + 22 * D) begin failures++; $display("FAIL bp_fall_cycle: got %0d want %0d", fall, start_cyc + 1 + 22 * D); end
    checks++; if (strobe_q.size() !== 21) begin failures++; $display("FAIL bp_strobe_count: got %0d want 21", strobe_q.size()); end
    for (int i = 0; i < 21; i++) begin
      checks++; if (i >= strobe_q.size() || strobe_q[i] !== 16'h0200 + 16'(2 * i)) begin failures++; $display("FAIL bp_sample[%0d]: got %h want %h", i, (i < strobe_q.size()) ? strobe_q[i] : '1, 16'h0200 + 16'(2 * i)); end
    end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL bp_underrun: got %b want 0", underrun); end
    play = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_underrun;
    int fall; bit to;
    ack_lat = D + 10;
    start_play(26'h20, 26'h21);
    repeat (D + 3) @(negedge clk);
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ur_set: got %b want 1", underrun); end
    checks++; if (strobe_q.size() !== 0) begin failures++; $display("FAIL ur_no_strobe: got %0d want 0", strobe_q.size()); end
    wait_busy_low(10 * D, fall, to);
    checks++; if (to) begin failures++; $display("FAIL ur_timeout: busy still %b want 0", busy); end
    checks++; if (fall !== start_cyc + 1 + 4 * D) begin failures++; $display("FAIL ur_fall_cycle: got %0d want %0d", fall, start_cyc + 1 + 4 * D); end
    checks++; if (strobe_q.size() !== 2 || strobe_q[0] !== 16'h0040 || strobe_q[1] !== 16'h0042) begin failures++; $display("FAIL ur_samples: got n=%0d want 0040,0042", strobe_q.size()); end
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ur_sticky: got %b want 1", underrun); end
    play = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort;
    bit seen_low;
    ack_lat = 60;
    start_play(26'h30, 26'h3f);
    repeat (10) @(negedge clk);
    checks++; if (rd_req !== 1'b1) begin failures++; $display("FAIL abort_in_wait: got rd_req=%b want 1", rd_req); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL abort_underrun_clear: got %b want 0", underrun); end
    play = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rd_req !== 1'b1) begin failures++; $display("FAIL abort_req_held: got %b want 1", rd_req); end
    seen_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!rd_req) begin seen_low = 1'b1; break; end
    end
    checks++; if (!seen_low) begin failures++; $display("FAIL abort_req_drop: rd_req still %b want 0", rd_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (60) @(negedge clk);
    checks++; if (strobe_q.size() !== 0) begin failures++; $display("FAIL abort_strobes: got %0d want 0", strobe_q.size()); end
    checks++; if (sample_out !== 16'h0042) begin failures++; $display("FAIL abort_sample_hold: got %h want 0042", sample_out); end
    checks++; if (req_q.size() !== 1 || rd_req !== 1'b0) begin failures++; $display("FAIL abort_no_more_req: got n=%0d rd_req=%b want 1/0", req_q.size(), rd_req); end
  endtask

  task automatic test_bad_range;
    ack_lat = 2;
    start_play(26'd5, 26'd4);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_range_busy_early: got %b want 0", busy); end
    repeat (48) @(negedge clk);
    checks++; if (busy !== 1'b0 || req_q.size() !== 0) begin failures++; $display("FAIL bad_range_idle: got busy=%b reqs=%0d want 0/0", busy, req_q.size()); end
    play = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_word;
    int fall; bit to;
    ack_lat = 2;
    start_play(26'd7, 26'd7);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_busy_low(5 * D, fall, to);
    checks++; if (to || fall !== start_cyc + 1 + 2 * D) begin failures++; $display("FAIL single_fall_cycle: got %0d want %0d", fall, start_cyc + 1 + 2 * D); end
    checks++; if (req_q.size() !== 1 || req_q[0] !== 26'd7) begin failures++; $display("FAIL single_req: got n=%0d want one at 7", req_q.size()); end
    checks++; if (strobe_q.size() !== 1 || strobe_q[0] !== 16'd14) begin failures++; $display("FAIL single_sample: got n=%0d want one of 000e", strobe_q.size()); end
    play = 1'b0;
    repeat (3) @(negedge clk);
  endtask

`ifdef SAMPLE_FETCH_LOOP_EN
  task automatic test_loop;
    int fall; bit to;
    ack_lat = 1;
    start_play(26'd0, 26'd2);
    repeat (3 * D) @(negedge clk);
    play = 1'b0;
    wait_busy_low(200, fall, to);
    checks++; if (to) begin failures++; $display("FAIL loop_stop: busy still %b want 0", busy); end
    checks++; if (req_q.size() < 9) begin failures++; $display("FAIL loop_req_count: got %0d want >=9", req_q.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (i >= req_q.size() || req_q[i] !== AW'(i % 3)) begin failures++; $display("FAIL loop_addr[%0d]: got %h want %0d", i, (i < req_q.size()) ? req_q[i] : '1, i % 3); end
    end
    repeat (5) @(negedge clk);
  endtask
`endif

  task automatic test_async_reset;
    bit seen;
    ack_lat = 20;
    start_play(26'h50, 26'h55);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_req) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL arst_req_seen: got rd_req=%b want 1", rd_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rd_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL arst_immediate: got rd_req=%b busy=%b want 0/0", rd_req, busy); end
    play = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin failures++; $display("FAIL arst_after: got busy=%b rd_req=%b want 0/0", busy, rd_req); end
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_underrun();
    test_abort();
    test_bad_range();
    test_single_word();
`ifdef SAMPLE_FETCH_LOOP_EN
    test_loop();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
